// File: rtl/i2c_spi_ctrl.sv
// i2c_spi_ctrl: sequences I2C write bytes into SPI transfers under a
// command-selected chip-select and queues MISO bytes for I2C read-back.
// The first byte of each I2C write is a command:
//   [1:0] chip-select index (clamped to NCS-1)
//   [6]   empty the read queue
//   [7]   hold the chip-select across STOP
// Every later byte is queued and sent as one 8-bit SPI transfer.
module i2c_spi_ctrl #(
  parameter int NCS         = 4,
  parameter int WFIFO_DEPTH = 4,
  parameter int RFIFO_DEPTH = 4,
  parameter int CS_SETUP    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     i2c_rx_data,
  input  logic           i2c_rx_valid,
  input  logic           i2c_busy,
  output logic [7:0]     i2c_tx_data,
  output logic           i2c_tx_valid,
  input  logic           i2c_tx_ready,
  output logic [7:0]     spi_tx,
  output logic           spi_start,
  input  logic           spi_done,
  input  logic [7:0]     spi_rx,
  input  logic           spi_busy,
  output logic [NCS-1:0] cs_n,
  output logic           ctrl_busy,
  output logic           wr_ovf,
  output logic           rd_ovf
);

  localparam int WAW = $clog2(WFIFO_DEPTH);
  localparam int RAW = $clog2(RFIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_START,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Transaction framing and command registers
  logic           r_busy_d;
  logic           r_first_byte;
  logic           r_end_pending;
  logic [1:0]     r_cs_idx;
  logic           r_hold_cs;
  logic [1:0]     w_cmd_idx;

  // Chip-select and timing registers
  logic [NCS-1:0] r_cs_n;
  logic [NCS-1:0] w_cs_n_nxt;
  logic [1:0]     r_act_idx;
  logic [1:0]     w_act_idx_nxt;
  logic [3:0]     r_cnt;
  logic [3:0]     w_cnt_nxt;
  logic [7:0]     r_spi_tx;
  logic           r_wr_ovf;
  logic           r_rd_ovf;

  // Write queue
  logic [7:0]     r_wmem [WFIFO_DEPTH];
  logic [WAW-1:0] r_wwr;
  logic [WAW-1:0] r_wrd;
  logic [WAW:0]   r_wcount;

  // Read queue
  logic [7:0]     r_rmem [RFIFO_DEPTH];
  logic [RAW-1:0] r_rwr;
  logic [RAW-1:0] r_rrd;
  logic [RAW:0]   r_rcount;

  // Decoded strobes
  logic           w_busy_rise;
  logic           w_busy_fall;
  logic           w_cmd_load;
  logic           w_data_push;
  logic           w_rd_clear;
  logic           w_cs_act;
  logic           w_wfull;
  logic           w_wempty;
  logic           w_wpush;
  logic           w_wpop;
  logic           w_wdrop;
  logic [7:0]     w_whead;
  logic           w_rfull;
  logic           w_rempty;
  logic           w_rpush_req;
  logic           w_rpush;
  logic           w_rpop;
  logic           w_rdrop;
  logic           w_spi_start;
  logic           w_end_clear;

  assign w_busy_rise = i2c_busy & ~r_busy_d;
  assign w_busy_fall = ~i2c_busy & r_busy_d;
  assign w_cmd_load  = i2c_rx_valid & r_first_byte;
  assign w_data_push = i2c_rx_valid & ~r_first_byte;
  assign w_rd_clear  = w_cmd_load & i2c_rx_data[6];
  assign w_cs_act    = ~(&r_cs_n);

  assign w_wfull  = (r_wcount == (WAW+1)'(WFIFO_DEPTH));
  assign w_wempty = (r_wcount == '0);
  assign w_whead  = r_wmem[r_wrd];
  assign w_wpush  = w_data_push & (~w_wfull | w_wpop);
  assign w_wdrop  = w_data_push & w_wfull & ~w_wpop;

  assign w_rfull  = (r_rcount == (RAW+1)'(RFIFO_DEPTH));
  assign w_rempty = (r_rcount == '0);
  assign w_rpop   = i2c_tx_ready & ~w_rempty;
  assign w_rpush  = w_rpush_req & (~w_rfull | w_rpop);
  assign w_rdrop  = w_rpush_req & w_rfull & ~w_rpop;

  assign i2c_tx_data  = w_rempty ? 8'hFF : r_rmem[r_rrd];
  assign i2c_tx_valid = ~w_rempty;
  assign spi_start    = w_spi_start;
  assign spi_tx       = w_spi_start ? w_whead : r_spi_tx;
  assign cs_n         = r_cs_n;
  assign ctrl_busy    = (r_state != ST_IDLE) | ~w_wempty | spi_busy;
  assign wr_ovf       = r_wr_ovf;
  assign rd_ovf       = r_rd_ovf;

  // Clamp an out-of-range command index to the highest chip-select
  always_comb begin
    w_cmd_idx = i2c_rx_data[1:0];
    if (int'(i2c_rx_data[1:0]) >= NCS) begin
      w_cmd_idx = 2'(NCS - 1);
    end
  end

  // Track I2C framing: first-byte flag, end-of-transaction request, command fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_d      <= 1'b0;
      r_first_byte  <= 1'b0;
      r_end_pending <= 1'b0;
      r_cs_idx      <= 2'd0;
      r_hold_cs     <= 1'b0;
    end else begin
      r_busy_d <= i2c_busy;
      if (w_busy_rise) begin
        r_first_byte <= 1'b1;
      end else if (w_cmd_load) begin
        r_first_byte <= 1'b0;
      end
      if (w_busy_fall) begin
        r_end_pending <= 1'b1;
      end else if (w_busy_rise || w_end_clear) begin
        r_end_pending <= 1'b0;
      end
      if (w_cmd_load) begin
        r_cs_idx  <= w_cmd_idx;
        r_hold_cs <= i2c_rx_data[7];
      end
    end
  end

  // Sticky overflow flags, cleared at the start of each I2C transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ovf <= 1'b0;
      r_rd_ovf <= 1'b0;
    end else begin
      if (w_wdrop) begin
        r_wr_ovf <= 1'b1;
      end else if (w_busy_rise) begin
        r_wr_ovf <= 1'b0;
      end
      if (w_rdrop && !w_rd_clear) begin
        r_rd_ovf <= 1'b1;
      end else if (w_busy_rise) begin
        r_rd_ovf <= 1'b0;
      end
    end
  end

  // Write-queue storage
  always_ff @(posedge clk) begin
    if (w_wpush) begin
      r_wmem[r_wwr] <= i2c_rx_data;
    end
  end

  // Write-queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wwr    <= '0;
      r_wrd    <= '0;
      r_wcount <= '0;
    end else begin
      if (w_wpush) begin
        r_wwr <= r_wwr + 1'b1;
      end
      if (w_wpop) begin
        r_wrd <= r_wrd + 1'b1;
      end
      if (w_wpush && !w_wpop) begin
        r_wcount <= r_wcount + 1'b1;
      end else if (!w_wpush && w_wpop) begin
        r_wcount <= r_wcount - 1'b1;
      end
    end
  end

  // Read-queue storage
  always_ff @(posedge clk) begin
    if (w_rpush) begin
      r_rmem[r_rwr] <= spi_rx;
    end
  end

  // Read-queue pointers and occupancy; a command clear overrides push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rwr    <= '0;
      r_rrd    <= '0;
      r_rcount <= '0;
    end else if (w_rd_clear) begin
      r_rwr    <= '0;
      r_rrd    <= '0;
      r_rcount <= '0;
    end else begin
      if (w_rpush) begin
        r_rwr <= r_rwr + 1'b1;
      end
      if (w_rpop) begin
        r_rrd <= r_rrd + 1'b1;
      end
      if (w_rpush && !w_rpop) begin
        r_rcount <= r_rcount + 1'b1;
      end else if (!w_rpush && w_rpop) begin
        r_rcount <= r_rcount - 1'b1;
      end
    end
  end

  // Hold the last byte sent so spi_tx stays stable between transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spi_tx <= 8'h00;
    end else if (w_spi_start) begin
      r_spi_tx <= w_whead;
    end
  end

  // Sequencer state, chip-select and setup/hold counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cs_n    <= '1;
      r_act_idx <= 2'd0;
      r_cnt     <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_act_idx <= w_act_idx_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  // Sequencer next-state: CS assert with setup, transfer loop, CS release with hold
  always_comb begin
    w_state_nxt   = r_state;
    w_cs_n_nxt    = r_cs_n;
    w_act_idx_nxt = r_act_idx;
    w_cnt_nxt     = r_cnt;
    w_spi_start   = 1'b0;
    w_wpop        = 1'b0;
    w_rpush_req   = 1'b0;
    w_end_clear   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_wempty) begin
          if (w_cs_act) begin
            if (r_act_idx == r_cs_idx) begin
              w_state_nxt = ST_START;
            end else begin
              w_cnt_nxt   = 4'(CS_SETUP);
              w_state_nxt = ST_RELEASE;
            end
          end else begin
            for (int i = 0; i < NCS; i++) begin
              w_cs_n_nxt[i] = (i != int'(r_cs_idx));
            end
            w_act_idx_nxt = r_cs_idx;
            w_cnt_nxt     = 4'(CS_SETUP);
            w_state_nxt   = ST_SETUP;
          end
        end else if (w_cs_act && r_end_pending && !r_hold_cs) begin
          w_cnt_nxt   = 4'(CS_SETUP);
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_SETUP: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_START;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_START: begin
        w_spi_start = 1'b1;
        w_wpop      = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (spi_done) begin
          w_rpush_req = 1'b1;
          w_state_nxt = w_wempty ? ST_IDLE : ST_START;
        end
      end
      ST_RELEASE: begin
        if (r_cnt <= 4'd1) begin
          w_cs_n_nxt  = '1;
          w_end_clear = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
